// File: rtl/rtc_pkg.sv
// Shared RTC bus definitions: register map, transfer commands, phase encoding
// and the transfer-index to address/data lookups used by the bus sequencers.
package rtc_pkg;

  localparam logic [7:0] RTC_SEG   = 8'h21;
  localparam logic [7:0] RTC_MIN   = 8'h22;
  localparam logic [7:0] RTC_HORA  = 8'h23;
  localparam logic [7:0] RTC_DIA   = 8'h24;
  localparam logic [7:0] RTC_MES   = 8'h25;
  localparam logic [7:0] RTC_ANIO  = 8'h26;
  localparam logic [7:0] RTC_TSEG  = 8'h41;
  localparam logic [7:0] RTC_TMIN  = 8'h42;
  localparam logic [7:0] RTC_THORA = 8'h43;

  localparam logic [7:0] CMD_RD_XFER = 8'hF0;
  localparam logic [7:0] CMD_WR_XFER = 8'hF1;

  localparam logic [3:0] CODE_CMD = 4'd9;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_SETUP,
    PH_STROBE,
    PH_HOLD,
    PH_GAP
  } phase_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } xfer_state_t;

  // Index 9 (and anything beyond) is the RAM-to-RTC transfer command.
  function automatic logic [7:0] xfer_addr(input logic [3:0] idx);
    case (idx)
      4'd0:    return RTC_SEG;
      4'd1:    return RTC_MIN;
      4'd2:    return RTC_HORA;
      4'd3:    return RTC_DIA;
      4'd4:    return RTC_MES;
      4'd5:    return RTC_ANIO;
      4'd6:    return RTC_TSEG;
      4'd7:    return RTC_TMIN;
      4'd8:    return RTC_THORA;
      default: return CMD_WR_XFER;
    endcase
  endfunction

  function automatic logic [7:0] xfer_data(input logic [71:0] d, input logic [3:0] idx);
    case (idx)
      4'd0:    return d[7:0];
      4'd1:    return d[15:8];
      4'd2:    return d[23:16];
      4'd3:    return d[31:24];
      4'd4:    return d[39:32];
      4'd5:    return d[47:40];
      4'd6:    return d[55:48];
      4'd7:    return d[63:56];
      4'd8:    return d[71:64];
      default: return CMD_WR_XFER;
    endcase
  endfunction

endpackage

// File: rtl/rtc_bus_phase_timer.sv
// Bus-cycle timing engine: runs one SETUP/STROBE/HOLD/GAP subcycle per start
// pulse and drives the registered CS_n/WR_n/bus strobes for it.
module rtc_bus_phase_timer
  import rtc_pkg::*;
#(
  parameter int T_SETUP  = 2,
  parameter int T_STROBE = 4,
  parameter int T_HOLD   = 2,
  parameter int T_GAP    = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       start,
  input  logic [7:0] value,
  output logic       cs_n,
  output logic       wr_n,
  output logic       oe,
  output logic [7:0] bus_out,
  output logic       sub_done
);

  phase_t     phase;
  logic [7:0] count;

  // High in the last GAP cycle so the next subcycle can start with no idle cycle.
  assign sub_done = (phase == PH_GAP) && (count == 8'd0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      phase   <= PH_IDLE;
      count   <= 8'd0;
      cs_n    <= 1'b1;
      wr_n    <= 1'b1;
      oe      <= 1'b0;
      bus_out <= 8'h00;
    end else if (start) begin
      phase   <= PH_SETUP;
      count   <= 8'(T_SETUP - 1);
      cs_n    <= 1'b0;
      wr_n    <= 1'b1;
      oe      <= 1'b1;
      bus_out <= value;
    end else if (count != 8'd0) begin
      count <= count - 8'd1;
    end else begin
      case (phase)
        PH_SETUP: begin
          phase <= PH_STROBE;
          count <= 8'(T_STROBE - 1);
          wr_n  <= 1'b0;
        end
        PH_STROBE: begin
          phase <= PH_HOLD;
          count <= 8'(T_HOLD - 1);
          wr_n  <= 1'b1;
        end
        PH_HOLD: begin
          phase   <= PH_GAP;
          count   <= 8'(T_GAP - 1);
          cs_n    <= 1'b1;
          oe      <= 1'b0;
          bus_out <= 8'h00;
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rtc_bus_writer.sv
// RTC write sequencer: latches nine bytes on Inicie, writes them to the time/
// date and timer registers, then issues the RAM-to-RTC transfer command.
module rtc_bus_writer
  import rtc_pkg::*;
#(
  parameter int T_SETUP  = 2,
  parameter int T_STROBE = 4,
  parameter int T_HOLD   = 2,
  parameter int T_GAP    = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Inicie,
  input  logic [71:0] Datos,
  output logic [7:0]  Bus_out,
  output logic        Bus_oe,
  output logic        AD,
  output logic        CS_n,
  output logic        WR_n,
  output logic        RD_n,
  output logic [3:0]  Code,
  output logic        Busy,
  output logic        Done
);

  xfer_state_t state;
  logic [3:0]  index;
  logic [71:0] latched;
  logic        accept;
  logic        last;
  logic        start;
  logic        sub_done;
  logic [7:0]  value;

  // A start coinciding with Done is dropped; the next cycle may start again.
  assign accept = (state == ST_IDLE) && Inicie && !Done;
  assign last   = (index == CODE_CMD);
  assign RD_n   = 1'b1;

  // value is what the timer latches onto the bus when start fires this edge.
  // NOTE: every always_comb output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    start = accept;
    value = xfer_addr(4'd0);
    case (state)
      ST_ADDR: begin
        start = sub_done;
        value = xfer_data(latched, index);
      end
      ST_DATA: begin
        start = sub_done && !last;
        value = xfer_addr(index + 4'd1);
      end
      default: ;
    endcase
  end

  // NOTE: the data latch has no reset; it is only read after being loaded,
  // and leaving it out keeps the wide register free of reset routing.
  always_ff @(posedge Clock) begin
    if (accept) latched <= Datos;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= ST_IDLE;
      index <= 4'd0;
      Code  <= CODE_CMD;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      AD    <= 1'b1;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_ADDR;
            index <= 4'd0;
            Code  <= 4'd0;
            Busy  <= 1'b1;
            AD    <= 1'b0;
          end
        end
        ST_ADDR: begin
          if (sub_done) begin
            state <= ST_DATA;
            AD    <= 1'b1;
          end
        end
        ST_DATA: begin
          if (sub_done) begin
            if (last) begin
              state <= ST_IDLE;
              index <= 4'd0;
              Code  <= CODE_CMD;
              Busy  <= 1'b0;
              Done  <= 1'b1;
            end else begin
              state <= ST_ADDR;
              index <= index + 4'd1;
              Code  <= index + 4'd1;
              AD    <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  rtc_bus_phase_timer #(
    .T_SETUP (T_SETUP),
    .T_STROBE(T_STROBE),
    .T_HOLD  (T_HOLD),
    .T_GAP   (T_GAP)
  ) u_timer (
    .Clock   (Clock),
    .Reset   (Reset),
    .start   (start),
    .value   (value),
    .cs_n    (CS_n),
    .wr_n    (WR_n),
    .oe      (Bus_oe),
    .bus_out (Bus_out),
    .sub_done(sub_done)
  );

endmodule

// File: tb/tb_rtc_bus_writer.sv
// Directed bench for rtc_bus_writer: default-timing and all-ones-timing
// instances observed through one selectable monitor.
module tb_rtc_bus_writer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        inicie = 1'b0;
  logic        sel = 1'b0;
  logic [71:0] datos = '0;

  logic        d_inicie, f_inicie;
  logic [7:0]  d_bus_out, f_bus_out, m_bus_out;
  logic        d_bus_oe, f_bus_oe, m_bus_oe;
  logic        d_ad, f_ad, m_ad;
  logic        d_cs_n, f_cs_n, m_cs_n;
  logic        d_wr_n, f_wr_n, m_wr_n;
  logic        d_rd_n, f_rd_n, m_rd_n;
  logic [3:0]  d_code, f_code, m_code;
  logic        d_busy, f_busy, m_busy;
  logic        d_done, f_done, m_done;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_addr [10] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43, 8'hF1};
  logic [7:0] exp_data [10];
  logic [7:0] cap_addr [10];
  logic [7:0] cap_data [10];
  int n_addr, n_data, busy_cnt, done_cnt, done_at, timing_bad, rd_bad, code_bad;

  always #5 Clock = ~Clock;

  assign d_inicie = sel ? 1'b0 : inicie;
  assign f_inicie = sel ? inicie : 1'b0;

  assign m_bus_out = sel ? f_bus_out : d_bus_out;
  assign m_bus_oe  = sel ? f_bus_oe  : d_bus_oe;
  assign m_ad      = sel ? f_ad      : d_ad;
  assign m_cs_n    = sel ? f_cs_n    : d_cs_n;
  assign m_wr_n    = sel ? f_wr_n    : d_wr_n;
  assign m_rd_n    = sel ? f_rd_n    : d_rd_n;
  assign m_code    = sel ? f_code    : d_code;
  assign m_busy    = sel ? f_busy    : d_busy;
  assign m_done    = sel ? f_done    : d_done;

  rtc_bus_writer dut (
    .Clock(Clock), .Reset(Reset), .Inicie(d_inicie), .Datos(datos),
    .Bus_out(d_bus_out), .Bus_oe(d_bus_oe), .AD(d_ad), .CS_n(d_cs_n),
    .WR_n(d_wr_n), .RD_n(d_rd_n), .Code(d_code), .Busy(d_busy), .Done(d_done)
  );

  rtc_bus_writer #(.T_SETUP(1), .T_STROBE(1), .T_HOLD(1), .T_GAP(1)) dut_fast (
    .Clock(Clock), .Reset(Reset), .Inicie(f_inicie), .Datos(datos),
    .Bus_out(f_bus_out), .Bus_oe(f_bus_oe), .AD(f_ad), .CS_n(f_cs_n),
    .WR_n(f_wr_n), .RD_n(f_rd_n), .Code(f_code), .Busy(f_busy), .Done(f_done)
  );

  // Pulses Inicie (cycle 0 = its sampling edge) and watches n_cycles cycles,
  // capturing address/data on WR_n rising and tallying timing violations.
  task automatic capture(input int n_cycles, input int inj1, input int inj2,
                         input int chg_at, input logic [71:0] chg_val,
                         input int e_setup, input int e_strobe, input int e_hold, input int e_gap);
    logic prev_cs, prev_wr, seen_low, ad0;
    logic [7:0] bus0;
    int cs_fall_k, cs_low_run, cs_high_run, wr_low_run;
    n_addr = 0; n_data = 0; busy_cnt = 0; done_cnt = 0; done_at = -1;
    timing_bad = 0; rd_bad = 0; code_bad = 0;
    for (int i = 0; i < 10; i++) begin
      cap_addr[i] = 'x;
      cap_data[i] = 'x;
    end
    prev_cs = 1'b1; prev_wr = 1'b1; seen_low = 1'b0; ad0 = 1'b0; bus0 = 8'h00;
    cs_fall_k = -100; cs_low_run = 0; cs_high_run = 0; wr_low_run = 0;
    @(negedge Clock);
    inicie = 1'b1;
    for (int k = 1; k <= n_cycles; k++) begin
      @(negedge Clock);
      inicie = (k == inj1) || (k == inj2);
      if (k == chg_at) datos = chg_val;
      if (m_busy) busy_cnt++;
      if (m_done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (m_rd_n !== 1'b1) rd_bad++;
      if (!m_busy && m_code !== 4'd9) code_bad++;
      if (m_cs_n == 1'b0) begin
        if (prev_cs) begin
          if (seen_low && cs_high_run != e_gap) timing_bad++;
          seen_low = 1'b1;
          cs_fall_k = k;
          cs_low_run = 0;
          ad0 = m_ad;
          bus0 = m_bus_out;
        end
        cs_low_run++;
        if (m_ad !== ad0 || m_bus_out !== bus0 || m_bus_oe !== 1'b1) timing_bad++;
      end else begin
        if (!prev_cs && cs_low_run != e_setup + e_strobe + e_hold) timing_bad++;
        cs_high_run = prev_cs ? cs_high_run + 1 : 1;
        if (m_bus_oe !== 1'b0 || m_bus_out !== 8'h00 || m_wr_n !== 1'b1) timing_bad++;
      end
      if (m_wr_n == 1'b0 && prev_wr) begin
        if (k - cs_fall_k != e_setup) timing_bad++;
        wr_low_run = 0;
      end
      if (m_wr_n == 1'b0) wr_low_run++;
      if (m_wr_n == 1'b1 && !prev_wr) begin
        if (wr_low_run != e_strobe) timing_bad++;
        if (m_ad == 1'b0) begin
          if (n_addr < 10) cap_addr[n_addr] = m_bus_out;
          if (m_code != 4'(n_addr)) code_bad++;
          n_addr++;
        end else begin
          if (n_data < 10) cap_data[n_data] = m_bus_out;
          if (m_code != 4'(n_data)) code_bad++;
          n_data++;
        end
      end
      prev_cs = m_cs_n;
      prev_wr = m_wr_n;
    end
    inicie = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    inicie = 1'b0;
    repeat (3) @(negedge Clock);
    checks++;
    if ({d_cs_n, d_wr_n, d_rd_n, d_ad, d_bus_oe} !== 5'b11110) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=11110", {d_cs_n, d_wr_n, d_rd_n, d_ad, d_bus_oe});
    end
    checks++;
    if (d_bus_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_bus_out got=%h exp=00", d_bus_out);
    end
    checks++;
    if ({d_busy, d_done, d_code} !== {2'b00, 4'd9}) begin
      failures++;
      $display("FAIL reset_status got busy=%b done=%b code=%0d exp 0 0 9", d_busy, d_done, d_code);
    end
    checks++;
    if ({f_cs_n, f_wr_n, f_bus_oe, f_busy, f_code} !== {3'b110, 1'b0, 4'd9}) begin
      failures++;
      $display("FAIL reset_fast got=%b exp=110_0_1001", {f_cs_n, f_wr_n, f_bus_oe, f_busy, f_code});
    end
    Reset = 1'b0;
    @(negedge Clock);
  endtask

  task automatic check_sequence(input string name, input int exp_done, input int exp_busy);
    checks++;
    if (n_addr != 10 || n_data != 10) begin
      failures++;
      $display("FAIL %s_count got addr=%0d data=%0d exp 10 10", name, n_addr, n_data);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({cap_addr[i], cap_data[i]} !== {exp_addr[i], exp_data[i]}) begin
        failures++;
        $display("FAIL %s_pair%0d got=%h/%h exp=%h/%h", name, i, cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]);
      end
    end
    checks++;
    if (done_at != exp_done || done_cnt != 1) begin
      failures++;
      $display("FAIL %s_done got at=%0d count=%0d exp at=%0d count=1", name, done_at, done_cnt, exp_done);
    end
    checks++;
    if (busy_cnt != exp_busy) begin
      failures++;
      $display("FAIL %s_busy_len got=%0d exp=%0d", name, busy_cnt, exp_busy);
    end
    checks++;
    if (timing_bad != 0 || rd_bad != 0 || code_bad != 0) begin
      failures++;
      $display("FAIL %s_timing got timing=%0d rd=%0d code=%0d exp 0 0 0", name, timing_bad, rd_bad, code_bad);
    end
  endtask

  task automatic test_full_sequence();
    datos = 72'h090807060504030201;
    for (int i = 0; i < 9; i++) exp_data[i] = 8'(i + 1);
    exp_data[9] = 8'hF1;
    capture(260, -1, -1, -1, '0, 2, 4, 2, 4);
    check_sequence("full", 241, 240);
  endtask

  task automatic test_ignore_while_busy();
    datos = 72'h998877665544332211;
    for (int i = 0; i < 9; i++) exp_data[i] = 8'((i + 1) * 17);
    exp_data[9] = 8'hF1;
    capture(260, 50, 120, 5, {72{1'b1}}, 2, 4, 2, 4);
    check_sequence("busy_ignore", 241, 240);
  endtask

  task automatic test_fast_timing();
    sel = 1'b1;
    datos = 72'h090807060504030201;
    for (int i = 0; i < 9; i++) exp_data[i] = 8'(i + 1);
    exp_data[9] = 8'hF1;
    capture(100, -1, -1, -1, '0, 1, 1, 1, 1);
    check_sequence("fast", 81, 80);
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic found;
    found = 1'b0;
    datos = 72'h090807060504030201;
    @(negedge Clock);
    inicie = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      @(negedge Clock);
      inicie = 1'b0;
      if (d_code == 4'd3 && d_ad == 1'b0 && d_wr_n == 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found || d_bus_out !== 8'h24) begin
      failures++;
      $display("FAIL midreset_reach got found=%b bus=%h exp found=1 bus=24", found, d_bus_out);
    end
    Reset = 1'b1;
    @(negedge Clock);
    checks++;
    if ({d_cs_n, d_wr_n, d_bus_oe, d_busy, d_done, d_code} !== {5'b11000, 4'd9}) begin
      failures++;
      $display("FAIL midreset_outputs got=%b exp=11000_1001", {d_cs_n, d_wr_n, d_bus_oe, d_busy, d_done, d_code});
    end
    Reset = 1'b0;
    for (int i = 0; i < 9; i++) exp_data[i] = 8'(i + 1);
    exp_data[9] = 8'hF1;
    capture(260, -1, -1, -1, '0, 2, 4, 2, 4);
    check_sequence("restart", 241, 240);
  endtask

  task automatic test_back_to_back();
    logic found;
    found = 1'b0;
    datos = 72'h090807060504030201;
    @(negedge Clock);
    inicie = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge Clock);
      inicie = 1'b0;
      if (d_done) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL b2b_first_done got=0 exp=1");
    end
    inicie = 1'b1;
    @(negedge Clock);
    checks++;
    if (d_busy !== 1'b0 || d_cs_n !== 1'b1) begin
      failures++;
      $display("FAIL b2b_done_cycle_ignored got busy=%b cs_n=%b exp 0 1", d_busy, d_cs_n);
    end
    @(negedge Clock);
    inicie = 1'b0;
    checks++;
    if ({d_busy, d_code, d_ad, d_cs_n, d_bus_out} !== {1'b1, 4'd0, 1'b0, 1'b0, 8'h21}) begin
      failures++;
      $display("FAIL b2b_restart got busy=%b code=%0d ad=%b cs_n=%b bus=%h exp 1 0 0 0 21",
               d_busy, d_code, d_ad, d_cs_n, d_bus_out);
    end
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_sequence();
    test_ignore_while_busy();
    test_fast_timing();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=expired exp=finish");
    $fatal(1, "timeout");
  end

endmodule
